// File: rtl/alu_seq_ctrl.sv
// Sequential unsigned ALU controller: ADD/SUB in one EXEC cycle, shift-and-add
// MUL and restoring DIV one bit per cycle, results held until the next completion.
module alu_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] rem,
   output logic             ovf,
   output logic             err
);

   localparam int             CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t state_q, state_d;

   // Captured operation
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [1:0]         op_q, op_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   // Multiplier working registers: multiplicand shifts left, multiplier shifts right
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplr_q, mplr_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;

   // Divider working registers: dividend shifts out MSB first into the partial remainder
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   prem_q, prem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;

   // Visible results
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               ovf_q, ovf_d;
   logic               err_q, err_d;

   // Single-step arithmetic
   logic [WIDTH:0]     add_full;
   logic [WIDTH:0]     sub_full;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_sub;
   logic               div_fits;
   logic [WIDTH-1:0]   prem_step;
   logic [WIDTH-1:0]   quo_step;
   logic               div_by_zero;
   logic               last_step;
   logic               exec_finish;

   assign add_full    = {1'b0, a_q} + {1'b0, b_q};
   // MSB of the extended difference is the borrow, i.e. a < b
   assign sub_full    = {1'b0, a_q} - {1'b0, b_q};
   assign acc_step    = acc_q + (mplr_q[0] ? mcand_q : '0);
   assign rem_shift   = {prem_q, dvd_q[WIDTH-1]};
   assign rem_sub     = rem_shift - {1'b0, b_q};
   assign div_fits    = (rem_shift >= {1'b0, b_q});
   // A restored remainder is always below b, so it fits back into WIDTH bits
   assign prem_step   = div_fits ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
   assign quo_step    = {quo_q[WIDTH-2:0], div_fits};
   assign div_by_zero = (b_q == '0);
   assign last_step   = (cnt_q == LAST_STEP);

   // Decide whether the current EXEC cycle is the final one for the captured op
   always_comb begin
      exec_finish = 1'b0;
      case (op_q)
         OP_ADD:  exec_finish = 1'b1;
         OP_SUB:  exec_finish = 1'b1;
         OP_MUL:  exec_finish = last_step;
         OP_DIV:  exec_finish = div_by_zero | last_step;
         default: exec_finish = 1'b1;
      endcase
   end

   // Next-state logic: IDLE -> EXEC on start, EXEC -> DONE on last step, DONE -> IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_EXEC;
         ST_EXEC: if (exec_finish) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: capture on accept, iterate in EXEC, publish results on finish
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      acc_d    = acc_q;
      dvd_d    = dvd_q;
      prem_d   = prem_q;
      quo_d    = quo_q;
      result_d = result_q;
      rem_d    = rem_q;
      ovf_d    = ovf_q;
      err_d    = err_q;

      if (state_q == ST_IDLE && start) begin
         a_d     = a;
         b_d     = b;
         op_d    = op;
         cnt_d   = '0;
         mcand_d = {{WIDTH{1'b0}}, a};
         mplr_d  = b;
         acc_d   = '0;
         dvd_d   = a;
         prem_d  = '0;
         quo_d   = '0;
      end else if (state_q == ST_EXEC) begin
         cnt_d = cnt_q + CW'(1);
         if (op_q == OP_MUL) begin
            acc_d   = acc_step;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
         end else if (op_q == OP_DIV && !div_by_zero) begin
            dvd_d  = dvd_q << 1;
            prem_d = prem_step;
            quo_d  = quo_step;
         end

         if (exec_finish) begin
            case (op_q)
               OP_ADD: begin
                  result_d = add_full[WIDTH-1:0];
                  rem_d    = '0;
                  ovf_d    = add_full[WIDTH];
                  err_d    = 1'b0;
               end
               OP_SUB: begin
                  result_d = sub_full[WIDTH-1:0];
                  rem_d    = '0;
                  ovf_d    = sub_full[WIDTH];
                  err_d    = 1'b0;
               end
               OP_MUL: begin
                  result_d = acc_step[WIDTH-1:0];
                  rem_d    = '0;
                  ovf_d    = |acc_step[2*WIDTH-1:WIDTH];
                  err_d    = 1'b0;
               end
               default: begin
                  if (div_by_zero) begin
                     result_d = '1;
                     rem_d    = a_q;
                     ovf_d    = 1'b0;
                     err_d    = 1'b1;
                  end else begin
                     result_d = quo_step;
                     rem_d    = prem_step;
                     ovf_d    = 1'b0;
                     err_d    = 1'b0;
                  end
               end
            endcase
         end
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplr_q   <= '0;
         acc_q    <= '0;
         dvd_q    <= '0;
         prem_q   <= '0;
         quo_q    <= '0;
         result_q <= '0;
         rem_q    <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         acc_q    <= acc_d;
         dvd_q    <= dvd_d;
         prem_q   <= prem_d;
         quo_q    <= quo_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign busy   = (state_q == ST_EXEC);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign rem    = rem_q;
   assign ovf    = ovf_q;
   assign err    = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: cycle-level arithmetic reference model compared every
// cycle, plus literal expectations for the documented example operations.
module tb_alu_seq_ctrl;

   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic [W-1:0] rem;
   logic         ovf;
   logic         err;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   alu_seq_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .rem    (rem),
      .ovf    (ovf),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, required %0d", nm, $time, act, exp);
      end
   endtask

   // Reference arithmetic: expected outputs and number of EXEC cycles
   function automatic void model_op(input int o, input int x, input int y,
                                    output int r, output int rm, output bit ov,
                                    output bit er, output int n);
      r = 0; rm = 0; ov = 0; er = 0; n = 1;
      case (o)
         0: begin r = (x + y) & MASK; ov = (x + y) > MASK; end
         1: begin r = (x - y) & MASK; ov = x < y; end
         2: begin r = (x * y) & MASK; ov = (x * y) > MASK; n = W; end
         default: begin
            if (y == 0) begin r = MASK; rm = x; er = 1; n = 1; end
            else begin r = x / y; rm = x % y; n = W; end
         end
      endcase
   endfunction

   // Model: cycles left in EXEC, pending results, and the published outputs
   int m_left = 0;
   bit m_done = 0;
   int m_res = 0, m_rem = 0;
   bit m_ovf = 0, m_err = 0;
   int p_res = 0, p_rem = 0;
   bit p_ovf = 0, p_err = 0;

   // Advance the reference model on every rising edge
   always @(posedge clk) begin : model
      int r, rm, n;
      bit ov, er;
      if (reset) begin
         m_left <= 0; m_done <= 0;
         m_res <= 0; m_rem <= 0; m_ovf <= 0; m_err <= 0;
      end else if (m_left > 0) begin
         if (m_left == 1) begin
            m_left <= 0; m_done <= 1;
            m_res <= p_res; m_rem <= p_rem; m_ovf <= p_ovf; m_err <= p_err;
         end else begin
            m_left <= m_left - 1;
         end
      end else if (m_done) begin
         m_done <= 0;
      end else if (start) begin
         model_op(int'(op), int'(a), int'(b), r, rm, ov, er, n);
         p_res <= r; p_rem <= rm; p_ovf <= ov; p_err <= er;
         m_left <= n;
      end
   end

   // Compare every output against the model mid-cycle
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("busy",   32'(busy),   32'(m_left > 0));
         cmp("done",   32'(done),   32'(m_done));
         cmp("result", 32'(result), 32'(m_res));
         cmp("rem",    32'(rem),    32'(m_rem));
         cmp("ovf",    32'(ovf),    32'(m_ovf));
         cmp("err",    32'(err),    32'(m_err));
      end
   end

   // Present an operation for one edge (DUT must be in IDLE), then scramble inputs
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
   endtask

   task automatic wait_done(input string nm, output int bcnt);
      bit ok;
      ok = 0; bcnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) begin ok = 1; break; end
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
      end
      cmp({nm, "_done_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic run(input string nm, input logic [1:0] o, input int x, input int y,
                      input int er, input int erm, input int eov, input int eerr, input int ebusy);
      int bc;
      issue(o, W'(x), W'(y));
      wait_done(nm, bc);
      $display("op %s: a=%0d b=%0d -> result=%0d rem=%0d ovf=%0d err=%0d busy_cycles=%0d",
               nm, x, y, result, rem, ovf, err, bc);
      cmp({nm, "_busy_cycles"}, 32'(bc), 32'(ebusy));
      cmp({nm, "_result"}, 32'(result), 32'(er));
      cmp({nm, "_rem"}, 32'(rem), 32'(erm));
      cmp({nm, "_ovf"}, 32'(ovf), 32'(eov));
      cmp({nm, "_err"}, 32'(err), 32'(eerr));
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcount, busy_after, r_cap;
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      cmp("reset_busy", 32'(busy), 32'd0);
      cmp("reset_done", 32'(done), 32'd0);
      cmp("reset_result", 32'(result), 32'd0);
      cmp("reset_rem_ovf_err", {rem, 22'd0, ovf, err}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run("ADD", 2'b00, 200, 100, 44, 0, 1, 0, 1);
      run("SUB1", 2'b01, 5, 7, 254, 0, 1, 0, 1);
      run("SUB2", 2'b01, 7, 5, 2, 0, 0, 0, 1);
      run("MUL1", 2'b10, 15, 17, 255, 0, 0, 0, 8);
      run("MUL2", 2'b10, 16, 16, 0, 0, 1, 0, 8);
      run("DIV1", 2'b11, 200, 7, 28, 4, 0, 0, 8);
      run("DIV0", 2'b11, 9, 0, 255, 9, 0, 1, 1);

      // MUL 3*4 with start pulses and changing operands during EXEC
      issue(2'b10, 8'd3, 8'd4);
      dcount = 0; busy_after = 0; r_cap = -1;
      for (int i = 0; i < 28; i++) begin
         if (done === 1'b1) begin
            dcount++;
            r_cap = int'(result);
            start = 1'b0;
         end else if (dcount == 0) begin
            start = 1'b1; op = 2'b00; a = W'($urandom); b = W'($urandom);
         end else if (busy === 1'b1) begin
            busy_after++;
         end
         @(negedge clk);
      end
      start = 1'b0;
      $display("op MUL_noise: a=3 b=4 -> result=%0d done_pulses=%0d busy_after=%0d",
               r_cap, dcount, busy_after);
      cmp("MUL_noise_done_pulses", 32'(dcount), 32'd1);
      cmp("MUL_noise_result", 32'(r_cap), 32'd12);
      cmp("MUL_noise_no_restart", 32'(busy_after), 32'd0);

      // Reset on the 4th EXEC cycle of a DIV
      issue(2'b11, 8'd200, 8'd7);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cmp("abort_busy", 32'(busy), 32'd0);
      cmp("abort_outputs", {8'd0, result, rem, 6'd0, ovf, err}, 32'd0);
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) dcount++;
         @(negedge clk);
      end
      $display("op DIV_abort: done_pulses=%0d", dcount);
      cmp("abort_no_done", 32'(dcount), 32'd0);
      run("ADD_after_abort", 2'b00, 1, 1, 2, 0, 0, 0, 1);

      // Randomized traffic checked cycle by cycle against the model
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 2) == 0);
         op    = 2'($urandom);
         case ($urandom_range(0, 5))
            0:       a = '0;
            1:       a = W'(MASK);
            default: a = W'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = W'(MASK);
            2:       b = 8'd1;
            default: b = W'($urandom);
         endcase
         if (done === 1'b1)
            $display("random txn: result=%0d rem=%0d ovf=%0d err=%0d", result, rem, ovf, err);
         @(negedge clk);
      end
      reset = 1'b0; start = 1'b0;
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
